// File: rtl/huff_pkg.sv
// Shared types for the Huffman front end: unpacker states, the byte type
// and the number of bytes carried by one 32-bit bus word.
package huff_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } unpack_state_e;

endpackage

// File: rtl/byte_unpacker_if.sv
// Bus bundle between the AHB slave stage (master side) and the byte
// unpacker (slave side). Byte handshake: byte_out is transferred on every
// rising HCLK where byte_valid=1 and byte_ready=1; while byte_valid=1 and
// byte_ready=0 the producer holds byte_out and byte_valid unchanged.
// dbg_state / dbg_fifo_empty expose the unpacker FSM and FIFO occupancy.
interface byte_unpacker_if #(parameter int CNT_W = 16);
   import huff_pkg::*;

   logic             start;
   logic             stop;
   logic [CNT_W-1:0] file_size;
   logic [31:0]      data_save;
   logic             data_valid;
   byte_t            byte_out;
   logic             byte_valid;
   logic             byte_ready;
   logic             done;
   logic             finish_all;
   logic             overflow;
   logic [1:0]       dbg_state;
   logic             dbg_fifo_empty;

   modport master (
      output start, stop, file_size, data_save, data_valid, byte_ready,
      input  byte_out, byte_valid, done, finish_all, overflow,
             dbg_state, dbg_fifo_empty
   );

   modport slave (
      input  start, stop, file_size, data_save, data_valid, byte_ready,
      output byte_out, byte_valid, done, finish_all, overflow,
             dbg_state, dbg_fifo_empty
   );

endinterface

// File: rtl/byte_unpacker_word_fifo.sv
// word_fifo: DEPTH x WIDTH synchronous FIFO. rdata_o always shows the head
// entry (no lookahead). The caller only pops when non-empty and only pushes
// into a full FIFO in the same cycle as a pop. flush_i empties it.
module word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);

   // Storage array: written at the tail pointer on push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy; power-of-2 depth lets the pointers wrap freely.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/byte_unpacker.sv
// byte_unpacker: buffers 32-bit words from the AHB stage and emits them one
// byte per cycle to the frequency counter. Optional macro BYTE_ORDER_MSB_EN
// emits [31:24] first instead of [7:0] first.
// The output byte is loaded from the FIFO head ahead of its handshake, so a
// separate load counter tracks bytes still to be fetched while bytes_left
// tracks bytes still to be accepted downstream.
module byte_unpacker
   import huff_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic             HCLK,
   input logic             HRESETn,
   byte_unpacker_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_RUN    = RUN;
   localparam logic [1:0] ST_FINISH = FINISH;
   localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

   logic [1:0]       state_q, state_d;
   logic             start_q;
   logic [CNT_W-1:0] bytes_left_q, bytes_left_d;
   logic [CNT_W-1:0] load_left_q, load_left_d;
   logic [1:0]       lane_q, lane_d;
   byte_t            byte_out_q, byte_out_d;
   logic             byte_valid_q, byte_valid_d;
   logic             overflow_q, overflow_d;
   logic             done_q;

   logic             start_rise, run, hs, load;
   logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [31:0]      fifo_rdata;
   logic [1:0]       byte_idx;
   byte_t            byte_sel;

   assign start_rise = bus.start & ~start_q;
   assign run        = (state_q == ST_RUN);
   assign hs         = byte_valid_q & bus.byte_ready;
   // Fetch the next byte whenever the output register is free or draining.
   assign load       = run & ~bus.stop & ~fifo_empty & (load_left_q != '0) &
                       (~byte_valid_q | hs);
   assign fifo_pop   = load & ((lane_q == LANE_LAST) | (load_left_q == CNT_W'(1)));
   // Full is judged after a same-cycle pop.
   assign fifo_push  = run & ~bus.stop & bus.data_valid & (~fifo_full | fifo_pop);
   // The FIFO only carries data while a file is running.
   assign fifo_flush = bus.stop | ~run;

`ifdef BYTE_ORDER_MSB_EN
   assign byte_idx = LANE_LAST - lane_q;
`else
   assign byte_idx = lane_q;
`endif
   assign byte_sel = fifo_rdata[{byte_idx, 3'b000} +: 8];

   word_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
      .clk_i   (HCLK),
      .rst_ni  (HRESETn),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (bus.data_save),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state logic for the FSM, counters and the output byte register.
   always_comb begin
      state_d      = state_q;
      bytes_left_d = bytes_left_q;
      load_left_d  = load_left_q;
      lane_d       = lane_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = byte_valid_q;
      overflow_d   = overflow_q;
      if (bus.stop) begin
         state_d      = ST_IDLE;
         byte_valid_d = 1'b0;
         lane_d       = '0;
         bytes_left_d = '0;
         load_left_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_rise) begin
                  if (bus.file_size != '0) begin
                     state_d      = ST_RUN;
                     bytes_left_d = bus.file_size;
                     load_left_d  = bus.file_size;
                     lane_d       = '0;
                     overflow_d   = 1'b0;
                  end else begin
                     state_d = ST_FINISH;
                  end
               end
            end
            ST_RUN: begin
               if (hs) begin
                  bytes_left_d = bytes_left_q - CNT_W'(1);
                  if (bytes_left_q == CNT_W'(1)) state_d = ST_FINISH;
               end
               if (load) begin
                  byte_out_d   = byte_sel;
                  byte_valid_d = 1'b1;
                  load_left_d  = load_left_q - CNT_W'(1);
                  lane_d       = fifo_pop ? 2'd0 : lane_q + 2'd1;
               end else if (hs) begin
                  byte_valid_d = 1'b0;
               end
               if (bus.data_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
            end
            ST_FINISH: begin
               if (!bus.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= ST_IDLE;
         start_q      <= 1'b0;
         bytes_left_q <= '0;
         load_left_q  <= '0;
         lane_q       <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= bus.start;
         bytes_left_q <= bytes_left_d;
         load_left_q  <= load_left_d;
         lane_q       <= lane_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         overflow_q   <= overflow_d;
         done_q       <= fifo_push;
      end
   end

   assign bus.byte_out       = byte_out_q;
   assign bus.byte_valid     = byte_valid_q;
   assign bus.done           = done_q;
   assign bus.finish_all     = (state_q == ST_FINISH);
   assign bus.overflow       = overflow_q;
   assign bus.dbg_state      = state_q;
   assign bus.dbg_fifo_empty = fifo_empty;

endmodule
